pxs_cursor_ctrl: RTL and testbench

//  Cursor position/blink controller for the text console. Accepts cursor-motion

---
 rtl/pxs_cursor_ctrl.sv | 132 +++++++++++++
 tb/tb_pxs_cursor_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pxs_cursor_ctrl.sv
// Text-console cursor position / scroll handshake / blink controller.
// Blink logic is built only with PXS_CURSOR_BLINK_EN defined.
module pxs_cursor_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       px_clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [6:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic       frame_tick,
  output logic       scroll_req,
  input  logic       scroll_ack,
  output logic [6:0] cursor_x,
  output logic [6:0] cursor_y,
  output logic [3:0] tcursor
);

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [6:0] YMAX = 7'(ROWS - 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RIGHT = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_CR    = 3'd5;
  localparam logic [2:0] OP_LF    = 3'd6;
  localparam logic [2:0] OP_SET   = 3'd7;

  typedef enum logic {
    IDLE,
    SCROLL_WAIT
  } state_t;

  state_t     state;
  logic       accept;
  logic [6:0] nx;
  logic [6:0] ny;
  logic       need_scroll;

  assign cmd_ready  = (state == IDLE);
  assign scroll_req = (state == SCROLL_WAIT);
  assign accept     = cmd_valid & cmd_ready;

  always_comb begin
    nx          = cursor_x;
    ny          = cursor_y;
    need_scroll = 1'b0;
    unique case (cmd)
      OP_RIGHT: begin
        if (cursor_x < XMAX) begin
          nx = cursor_x + 7'd1;
        end else begin
          nx = 7'd0;
          if (cursor_y < YMAX) ny = cursor_y + 7'd1;
          else need_scroll = 1'b1;
        end
      end
      OP_LEFT: if (cursor_x != 7'd0) nx = cursor_x - 7'd1;
      OP_UP:   if (cursor_y != 7'd0) ny = cursor_y - 7'd1;
      OP_DOWN: if (cursor_y < YMAX) ny = cursor_y + 7'd1;
      OP_CR:   nx = 7'd0;
      OP_LF: begin
        if (cursor_y < YMAX) ny = cursor_y + 7'd1;
        else need_scroll = 1'b1;
      end
      OP_SET: begin
        nx = (cmd_x > XMAX) ? XMAX : cmd_x;
        ny = (cmd_y > YMAX) ? YMAX : cmd_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cursor_x <= 7'd0;
      cursor_y <= 7'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cursor_x <= nx;
            cursor_y <= ny;
            if (need_scroll) state <= SCROLL_WAIT;
          end
        end
        SCROLL_WAIT: if (scroll_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PXS_CURSOR_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BMAX = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] blink_cnt;
  logic          blink_vis;

  // A move restarts the blink so the cursor is visible right away.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (accept && cmd != OP_NOP) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BMAX) begin
        blink_cnt <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign tcursor = {3'b000, blink_vis};
`else
  logic unused_tick;
  assign unused_tick = frame_tick;
  assign tcursor     = 4'b0001;
`endif

endmodule

// File: tb/tb_pxs_cursor_ctrl.sv
// Directed bench for pxs_cursor_ctrl: motion, wrap, clamp,
// scroll handshake, blink and async reset.
module tb_pxs_cursor_ctrl;

  logic       px_clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [6:0] cmd_x;
  logic [6:0] cmd_y;
  logic       frame_tick;
  logic       scroll_req;
  logic       scroll_ack;
  logic [6:0] cursor_x;
  logic [6:0] cursor_y;
  logic [3:0] tcursor;

  int checks = 0;
  int errors = 0;

  pxs_cursor_ctrl #(.COLS(80), .ROWS(60), .BLINK_FRAMES(30)) dut (
    .px_clk     (px_clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .frame_tick (frame_tick),
    .scroll_req (scroll_req),
    .scroll_ack (scroll_ack),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .tcursor    (tcursor)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic send(input logic [2:0] c, input logic [6:0] xx,
                      input logic [6:0] yy);
    cmd       = c;
    cmd_x     = xx;
    cmd_y     = yy;
    cmd_valid = 1'b1;
    @(posedge px_clk); #1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge px_clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    checks++;
    if ({cursor_x, cursor_y} !== 14'd0) begin
      errors++;
      $display("FAIL reset_pos got %0d,%0d want 0,0", cursor_x, cursor_y);
    end
    checks++;
    if ({tcursor, scroll_req, cmd_ready} !== 6'b000101) begin
      errors++;
      $display("FAIL reset_flags got tc=%b req=%b rdy=%b want 0001 0 1",
               tcursor, scroll_req, cmd_ready);
    end
    rst_n = 1'b1;
    @(posedge px_clk); #1;
  endtask

  task automatic test_right();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL right_ready[%0d] got %b want 1", i, cmd_ready);
      end
      send(3'd1, 7'd0, 7'd0);
    end
    checks++;
    if (cursor_x !== 7'd3 || cursor_y !== 7'd0) begin
      errors++;
      $display("FAIL right_x3 got %0d,%0d want 3,0", cursor_x, cursor_y);
    end
  endtask

  task automatic test_wrap_clamp();
    send(3'd7, 7'd79, 7'd5);
    send(3'd1, 7'd0, 7'd0);
    checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 7'd6) begin
      errors++;
      $display("FAIL line_wrap got %0d,%0d want 0,6", cursor_x, cursor_y);
    end
    send(3'd7, 7'd100, 7'd90);
    checks++;
    if (cursor_x !== 7'd79 || cursor_y !== 7'd59) begin
      errors++;
      $display("FAIL set_clamp got %0d,%0d want 79,59", cursor_x, cursor_y);
    end
    send(3'd5, 7'd0, 7'd0);
    checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 7'd59) begin
      errors++;
      $display("FAIL cr got %0d,%0d want 0,59", cursor_x, cursor_y);
    end
  endtask

  task automatic test_scroll();
    int hi;
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    scroll_ack = 1'b0;
    checks++;
    if (scroll_req !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack got req=%b rdy=%b want 0 1", scroll_req, cmd_ready);
    end
    send(3'd7, 7'd10, 7'd59);
    send(3'd6, 7'd0, 7'd0);
    checks++;
    if ({cursor_x, cursor_y, scroll_req, cmd_ready} !== {7'd10, 7'd59, 2'b10}) begin
      errors++;
      $display("FAIL lf_scroll got %0d,%0d req=%b rdy=%b want 10,59 1 0",
               cursor_x, cursor_y, scroll_req, cmd_ready);
    end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) send(3'd1, 7'd0, 7'd0);
      else begin
        @(posedge px_clk); #1;
      end
      if (scroll_req === 1'b1) hi++;
    end
    checks++;
    if (hi !== 20) begin
      errors++;
      $display("FAIL scroll_hold got %0d cycles high want 20", hi);
    end
    checks++;
    if (cursor_x !== 7'd10 || cursor_y !== 7'd59) begin
      errors++;
      $display("FAIL cmd_blocked got %0d,%0d want 10,59", cursor_x, cursor_y);
    end
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    scroll_ack = 1'b0;
    checks++;
    if (scroll_req !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL scroll_done got req=%b rdy=%b want 0 1", scroll_req, cmd_ready);
    end
    send(3'd7, 7'd79, 7'd59);
    send(3'd1, 7'd0, 7'd0);
    checks++;
    if ({cursor_x, cursor_y, scroll_req} !== {7'd0, 7'd59, 1'b1}) begin
      errors++;
      $display("FAIL right_scroll got %0d,%0d req=%b want 0,59 1",
               cursor_x, cursor_y, scroll_req);
    end
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    scroll_ack = 1'b0;
  endtask

  task automatic test_edges();
    send(3'd7, 7'd0, 7'd0);
    send(3'd2, 7'd0, 7'd0);
    send(3'd3, 7'd0, 7'd0);
    checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 7'd0) begin
      errors++;
      $display("FAIL left_up_hold got %0d,%0d want 0,0", cursor_x, cursor_y);
    end
    send(3'd7, 7'd5, 7'd59);
    send(3'd4, 7'd0, 7'd0);
    checks++;
    if ({cursor_x, cursor_y, scroll_req} !== {7'd5, 7'd59, 1'b0}) begin
      errors++;
      $display("FAIL down_bottom got %0d,%0d req=%b want 5,59 0",
               cursor_x, cursor_y, scroll_req);
    end
    send(3'd3, 7'd0, 7'd0);
    send(3'd4, 7'd0, 7'd0);
    checks++;
    if (cursor_y !== 7'd59) begin
      errors++;
      $display("FAIL up_down got y=%0d want 59", cursor_y);
    end
  endtask

  task automatic test_blink();
`ifdef PXS_CURSOR_BLINK_EN
    tick(29);
    checks++;
    if (tcursor !== 4'b0001) begin
      errors++;
      $display("FAIL blink_29 got %b want 0001", tcursor);
    end
    tick(1);
    checks++;
    if (tcursor !== 4'b0000) begin
      errors++;
      $display("FAIL blink_30 got %b want 0000", tcursor);
    end
    tick(30);
    checks++;
    if (tcursor !== 4'b0001) begin
      errors++;
      $display("FAIL blink_60 got %b want 0001", tcursor);
    end
    tick(30);
    send(3'd2, 7'd0, 7'd0);
    checks++;
    if (tcursor !== 4'b0001) begin
      errors++;
      $display("FAIL move_visible got %b want 0001", tcursor);
    end
    tick(15);
    frame_tick = 1'b1;
    send(3'd2, 7'd0, 7'd0);
    frame_tick = 1'b0;
    tick(29);
    checks++;
    if (tcursor !== 4'b0001) begin
      errors++;
      $display("FAIL restart_29 got %b want 0001", tcursor);
    end
    tick(1);
    checks++;
    if (tcursor !== 4'b0000) begin
      errors++;
      $display("FAIL restart_30 got %b want 0000", tcursor);
    end
    send(3'd0, 7'd0, 7'd0);
    checks++;
    if (tcursor !== 4'b0000) begin
      errors++;
      $display("FAIL nop_keeps got %b want 0000", tcursor);
    end
    send(3'd5, 7'd0, 7'd0);
`else
    tick(45);
    checks++;
    if (tcursor !== 4'b0001) begin
      errors++;
      $display("FAIL blink_off got %b want 0001", tcursor);
    end
`endif
  endtask

  task automatic test_reset_mid_scroll();
    send(3'd7, 7'd3, 7'd59);
    send(3'd6, 7'd0, 7'd0);
    checks++;
    if (scroll_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_req got %b want 1", scroll_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({scroll_req, cmd_ready, cursor_x, cursor_y} !== {2'b01, 14'd0}) begin
      errors++;
      $display("FAIL async_rst got req=%b rdy=%b %0d,%0d want 0 1 0,0",
               scroll_req, cmd_ready, cursor_x, cursor_y);
    end
    @(posedge px_clk); #1;
    rst_n = 1'b1;
    send(3'd1, 7'd0, 7'd0);
    checks++;
    if (cursor_x !== 7'd1 || scroll_req !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got x=%0d req=%b want 1 0", cursor_x, scroll_req);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'd0;
    cmd_x      = 7'd0;
    cmd_y      = 7'd0;
    frame_tick = 1'b0;
    scroll_ack = 1'b0;
    test_reset();
    test_right();
    test_wrap_clamp();
    test_scroll();
    test_edges();
    test_blink();
    test_reset_mid_scroll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
